univ_shift_reg: RTL and testbench

Parametrised successor to the team's 4-bit reset/set/load register. Adds configurable width, a shift/rotate mode bus with serial in/out, and a multi-cycle burst-shift engine with a busy/done handshake. Used as a general-purpose datapath register and serialiser in lab designs.

---
 rtl/univ_shift_reg_if.sv | 39 +++
 rtl/univ_shift_reg.sv | 101 ++++++++++
 tb/tb_univ_shift_reg.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle for univ_shift_reg.
// Optional parity output exists only when PARITY_EN is defined.
interface univ_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             set;
  logic             load;
  logic [WIDTH-1:0] D;
  logic [2:0]       mode;
  logic             ser_in;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] Q;
  logic             ser_out;
  logic             busy;
  logic             done;
`ifdef PARITY_EN
  logic             parity;

  modport master (
    output set, load, D, mode, ser_in, start, amt,
    input  Q, ser_out, busy, done, parity
  );
  modport slave (
    input  set, load, D, mode, ser_in, start, amt,
    output Q, ser_out, busy, done, parity
  );
`else
  modport master (
    output set, load, D, mode, ser_in, start, amt,
    input  Q, ser_out, busy, done
  );
  modport slave (
    input  set, load, D, mode, ser_in, start, amt,
    output Q, ser_out, busy, done
  );
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: set/load register with shift/rotate modes and burst engine.
// Optional feature macro: PARITY_EN (adds XOR-reduction parity output).
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  univ_shift_reg_if.slave bus
);

  localparam logic [2:0] M_SHL = 3'b001;
  localparam logic [2:0] M_SHR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [2:0] M_ASR = 3'b101;

  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_mode;

  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_idle_nxt;
  logic [WIDTH-1:0] w_burst_nxt;
  logic             w_last;

  function automatic logic [WIDTH-1:0] f_step(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic             sin
  );
    logic [WIDTH-1:0] n;
    n = q;
    case (op)
      M_SHL:   n = {q[WIDTH-2:0], sin};
      M_SHR:   n = {sin, q[WIDTH-1:1]};
      M_ROL:   n = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   n = {q[0], q[WIDTH-1:1]};
      M_ASR:   n = {q[WIDTH-1], q[WIDTH-1:1]};
      default: n = q;
    endcase
    return n;
  endfunction

  // Next-state candidates and the effective mode seen by ser_out.
  always_comb begin
    w_mode      = r_busy ? r_mode : bus.mode;
    w_idle_nxt  = f_step(bus.mode, r_q, bus.ser_in);
    w_burst_nxt = f_step(r_mode, r_q, bus.ser_in);
    w_last      = (r_cnt == AMT_W'(1));
  end

  // Register, burst counter and done pulse; set > load > burst > idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_mode <= 3'b000;
    end else begin
      r_done <= 1'b0;
      if (bus.set) begin
        r_q    <= '1;
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (bus.load) begin
        r_q    <= bus.D;
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (r_busy) begin
        r_q   <= w_burst_nxt;
        r_cnt <= r_cnt - AMT_W'(1);
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (bus.start) begin
        r_mode <= bus.mode;
        r_cnt  <= bus.amt;
        if (bus.amt == '0) r_done <= 1'b1;
        else               r_busy <= 1'b1;
      end else begin
        r_q <= w_idle_nxt;
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ser_out = (w_mode == M_SHL || w_mode == M_ROL)
                     ? r_q[WIDTH-1] : r_q[0];

`ifdef PARITY_EN
  assign bus.parity = ^r_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard-driven bench for univ_shift_reg.
// Expected Q/busy/done queued per edge, popped after the edge.
module tb_univ_shift_reg;
  localparam int W = 4;
  localparam int A = 3;

  logic clk = 1'b0;
  logic reset;

  univ_shift_reg_if #(.WIDTH(W), .AMT_W(A)) bus ();

  univ_shift_reg #(.WIDTH(W), .AMT_W(A)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  typedef struct packed {
    logic         set;
    logic         load;
    logic [W-1:0] d;
    logic [2:0]   md;
    logic         sin;
    logic         st;
    logic [A-1:0] am;
    exp_t         ex;
  } vec_t;

  exp_t sb[$];
  int nerr = 0;
  int nchk = 0;

  function automatic vec_t mk(
    input logic s, input logic l, input logic [W-1:0] d,
    input logic [2:0] md, input logic sin, input logic st,
    input logic [A-1:0] am, input logic [W-1:0] q,
    input logic b, input logic dn
  );
    vec_t v;
    v.set = s; v.load = l; v.d = d; v.md = md; v.sin = sin;
    v.st = st; v.am = am; v.ex.q = q; v.ex.busy = b; v.ex.done = dn;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.set = v.set; bus.load = v.load; bus.D = v.d;
    bus.mode = v.md; bus.ser_in = v.sin;
    bus.start = v.st; bus.amt = v.am;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[4];
    exp_t e;
    drive(mk(0,0,4'h0,3'd0,0,0,3'd0,4'h0,0,0));
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    sb.push_back('{q:4'h0, busy:1'b0, done:1'b0});
    e = sb.pop_front();
    nchk++;
    if ({bus.Q, bus.busy, bus.done} !== e) begin
      nerr++;
      $display("FAIL reset: got q=%b b=%b d=%b want q=%b b=%b d=%b",
               bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
    end
    @(negedge clk) reset = 1'b0;
    v[0] = mk(1,0,4'h0,3'd0,0,0,3'd0,4'b1111,0,0);
    v[1] = mk(0,1,4'b1010,3'd0,0,0,3'd0,4'b1010,0,0);
    v[2] = mk(0,0,4'h0,3'd0,0,0,3'd0,4'b1010,0,0);
    v[3] = mk(0,0,4'h0,3'd0,0,0,3'd0,4'b1010,0,0);
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL set_load[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[2];
    logic so[2];
    exp_t e;
    v[0] = mk(0,0,4'h0,3'b001,1,0,3'd0,4'b0101,0,0);
    v[1] = mk(0,0,4'h0,3'b001,1,0,3'd0,4'b1011,0,0);
    so[0] = 1'b1;
    so[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(v[i]);
      #1;
      nchk++;
      if (bus.ser_out !== so[i]) begin
        nerr++;
        $display("FAIL shl_ser_out[%0d]: got %b want %b", i, bus.ser_out, so[i]);
      end
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL shl[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_rotate();
    vec_t v[8];
    exp_t e;
    v[0] = mk(0,1,4'b0110,3'b000,0,0,3'd0,4'b0110,0,0);
    v[1] = mk(0,0,4'h0,3'b100,0,0,3'd0,4'b0011,0,0);
    v[2] = mk(0,0,4'h0,3'b100,0,0,3'd0,4'b1001,0,0);
    v[3] = mk(0,0,4'h0,3'b100,0,0,3'd0,4'b1100,0,0);
    v[4] = mk(0,0,4'h0,3'b100,0,0,3'd0,4'b0110,0,0);
    v[5] = mk(0,1,4'b1000,3'b000,0,0,3'd0,4'b1000,0,0);
    v[6] = mk(0,0,4'h0,3'b101,0,0,3'd0,4'b1100,0,0);
    v[7] = mk(0,0,4'h0,3'b101,0,0,3'd0,4'b1110,0,0);
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL ror_asr[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    exp_t e;
    v[0] = mk(0,0,4'h0,3'b010,0,0,3'd0,4'b0111,0,0);
    v[1] = mk(0,0,4'h0,3'b010,1,0,3'd0,4'b1011,0,0);
    v[2] = mk(0,0,4'h0,3'b110,1,0,3'd0,4'b1011,0,0);
    v[3] = mk(0,0,4'h0,3'b111,0,0,3'd0,4'b1011,0,0);
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL shr_hold[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_burst();
    vec_t v[6];
    exp_t e;
    v[0] = mk(0,1,4'b0001,3'b000,0,0,3'd0,4'b0001,0,0);
    v[1] = mk(0,0,4'h0,3'b011,0,1,3'd3,4'b0001,1,0);
    v[2] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b0010,1,0);
    v[3] = mk(0,0,4'h0,3'b001,1,1,3'd5,4'b0100,1,0);
    v[4] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b1000,0,1);
    v[5] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b1000,0,0);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL burst[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_abort();
    vec_t v[9];
    exp_t e;
    v[0] = mk(0,0,4'h0,3'b011,0,1,3'd3,4'b1000,1,0);
    v[1] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b0001,1,0);
    v[2] = mk(0,1,4'b0111,3'b000,0,0,3'd0,4'b0111,0,0);
    v[3] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b0111,0,0);
    v[4] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b0111,0,0);
    v[5] = mk(0,0,4'h0,3'b001,1,1,3'd0,4'b0111,0,1);
    v[6] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b0111,0,0);
    v[7] = mk(1,0,4'h0,3'b011,0,1,3'd2,4'b1111,0,0);
    v[8] = mk(0,0,4'h0,3'b000,0,0,3'd0,4'b1111,0,0);
    for (int i = 0; i < 9; i++) begin
      drive(v[i]);
      if (i == 1) begin
        #1;
        nchk++;
        if (bus.ser_out !== 1'b1) begin
          nerr++;
          $display("FAIL latched_ser_out: got %b want 1", bus.ser_out);
        end
      end
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL abort[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t v[2];
    exp_t e;
    v[0] = mk(0,1,4'b0001,3'b000,0,0,3'd0,4'b0001,0,0);
    v[1] = mk(0,0,4'h0,3'b001,0,1,3'd7,4'b0001,1,0);
    for (int i = 0; i < 2; i++) begin
      drive(v[i]);
      sb.push_back(v[i].ex);
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL pre_rst[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    drive(mk(0,0,4'h0,3'b000,0,0,3'd0,4'h0,0,0));
    tick();
    #1 reset = 1'b1;
    #1;
    sb.push_back('{q:4'h0, busy:1'b0, done:1'b0});
    e = sb.pop_front();
    nchk++;
    if ({bus.Q, bus.busy, bus.done} !== e) begin
      nerr++;
      $display("FAIL async_rst: got q=%b b=%b d=%b want q=%b b=%b d=%b",
               bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{q:4'h0, busy:1'b0, done:1'b0});
      tick();
      e = sb.pop_front();
      nchk++;
      if ({bus.Q, bus.busy, bus.done} !== e) begin
        nerr++;
        $display("FAIL post_rst[%0d]: got q=%b b=%b d=%b want q=%b b=%b d=%b",
                 i, bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_rotate();
    test_back_to_back();
    test_burst();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
